cska_pipe: RTL and testbench
============================

// Module: cska_pipe
// PURPOSE
//   Parametrised, pipelined carry-skip adder/subtractor with valid/ready handshake.
//   It is the successor to the fixed 32-bit, 4-bit-block combinational carry-skip adder.
//   Operands are split into BLK-bit ripple blocks with skip (block-propagate) muxes.
//   BPS blocks are evaluated per pipeline stage, giving throughput of 1 op/cycle.
//   It sits in the arithmetic datapath between the operand-issue and writeback stages.
// PARAMETERS
//   WIDTH  32  operand/sum width in bits; WIDTH % BLK == 0 required
//   BLK     4  bits per ripple-carry block; BLK >= 2
//   BPS     2  carry-skip blocks resolved per pipeline stage; BPS >= 1
//   Derived: NBLK = WIDTH/BLK; L = ceil(NBLK/BPS) stages.
//   Any illegal value causes an elaboration error ($error in generate).
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      cska_pipe can accept a beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry in (add mode only)
//   sub        in   1      0: a+b+cin; 1: a-b (= a+~b+1, cin ignored)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of MSB; in sub mode 1 = no borrow
//   ovf        out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//   Reset (async, rst_n=0): every stage valid=0 and every data reg=0.
//     Outputs: out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 once rst_n=1.
//   Accept occurs when in_valid && in_ready. Stage 0 captures a, b_eff=sub?~b:b,
//     c_eff=sub?1:cin.
//   Stage k (0..L-1) resolves blocks [k*BPS, min((k+1)*BPS,NBLK)-1].
//     Per block: P = &(a^b); cout_blk = P ? cin_blk : ripple carry.
//     The stage registers its sum bits, the inter-stage carry, and the unconsumed
//     upper operand bits. Already-produced low sum bits travel down the pipe.
//     The last stage may hold fewer than BPS blocks (ragged).
//   Latency: result appears on out_valid exactly L cycles after accept, if there
//     is no backpressure. Default L = 4.
//   Flow control is elastic and bubble-collapsing.
//     Stage i advances if !v[i+1] || adv[i+1]. The last stage advances if
//       !out_valid || out_ready.
//     in_ready = !v[0] || adv[0]; the combinational path out_ready->in_ready is
//       permitted.
//   Stall: while out_valid && !out_ready, sum/cout/ovf/out_valid are held stable.
//     No beat is dropped or duplicated, and order is preserved (FIFO).
//   Capacity: L beats in flight. in_ready=0 only when all stages are valid and
//     the output is stalled.
//   Simultaneous accept and output in the same cycle: both occur; occupancy is
//     unchanged.
//   in_valid low: bubbles enter the pipe. Data regs may hold stale values; only
//     the valid bits matter.
//   Reset mid-operation: all in-flight beats are discarded and out_valid drops
//     immediately (async). No stale result is emitted after release.
//   BPS >= NBLK: the whole add happens in one stage, L=1, output still registered.
//   No X propagation: data regs are reset, so sum is never X after reset.
// TESTING (WIDTH=32, BLK=4, BPS=2, L=4 unless stated)
//   1 Reset: assert rst_n=0 mid-idle -> out_valid=0, sum=0, cout=0, ovf=0;
//     after release in_ready=1.
//   2 Full skip chain: a=0xFFFFFFFF, b=0, cin=1, sub=0 -> 4 cycles later
//     sum=0x00000000, cout=1, ovf=0.
//   3 Signed overflow: a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1.
//   4 Subtract: sub=1, a=5, b=7, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0.
//     Then a=7, b=5 -> sum=2, cout=1.
//   5 Backpressure: 8 back-to-back beats, a=i, b=i<<4, with out_ready low for
//     cycles 3-8 -> in_ready falls once 4 beats are held. All 8 results arrive in
//     order, each stable while stalled.
//   6 Reset with 3 beats in flight -> out_valid=0 at once; no output until new
//     beats are accepted. Then run 10k random beats (random stalls) against a
//     behavioural model at WIDTH=16/BLK=4/BPS=1 and WIDTH=64/BLK=8/BPS=3 (ragged,
//     L=3).

Source files
------------

// File: rtl/cska_pipe.sv
// Pipelined carry-skip adder/subtractor; each stage resolves BPS ripple blocks with skip muxes.
// Latency: L = ceil((WIDTH/BLK)/BPS) cycles from accept to out_valid; one op per cycle.
// Backpressure: elastic and bubble-collapsing; out_ready reaches in_ready combinationally.
module cska_pipe #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4,
    parameter int BPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLK;
    localparam int L    = (NBLK + BPS - 1) / BPS;
    localparam int LR   = (L > 1) ? L - 1 : 1;

    if (BLK < 2) begin : g_bad_blk
        $error("cska_pipe: BLK must be >= 2");
    end
    if (WIDTH % BLK != 0) begin : g_bad_width
        $error("cska_pipe: WIDTH must be a multiple of BLK");
    end
    if (BPS < 1) begin : g_bad_bps
        $error("cska_pipe: BPS must be >= 1");
    end

    // Stage inputs: operands, partial sum and carry entering the combinational slice of stage k.
    logic [WIDTH-1:0] st_a  [L];
    logic [WIDTH-1:0] st_b  [L];
    logic [WIDTH-1:0] st_s  [L];
    logic [L-1:0]     st_c;
    logic [L-1:0]     st_v;

    // Register outputs of each stage.
    logic [WIDTH-1:0] opa_q [LR];
    logic [WIDTH-1:0] opb_q [LR];
    logic [WIDTH-1:0] sum_q [L];
    logic [L-1:0]     c_q;
    logic [L-1:0]     v_q;
    logic [L-1:0]     en;
    logic             ovf_q;

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int LO = k * BPS;
        localparam int HI = ((k + 1) * BPS < NBLK) ? (k + 1) * BPS : NBLK;

        logic [WIDTH-1:0] ns;
        logic             nc;
        logic             rc;
        logic             pb;
        logic             bp;
        int               idx;
        logic [WIDTH-1:0] s_r;
        logic             c_r;
        logic             v_r;

        if (k == 0) begin : g_head
            assign st_a[k] = a;
            assign st_b[k] = sub ? ~b : b;
            assign st_s[k] = '0;
            assign st_c[k] = sub | cin;
            assign st_v[k] = in_valid;
        end else begin : g_body
            assign st_a[k] = opa_q[k-1];
            assign st_b[k] = opb_q[k-1];
            assign st_s[k] = sum_q[k-1];
            assign st_c[k] = c_q[k-1];
            assign st_v[k] = v_q[k-1];
        end

        always_comb begin
            ns  = st_s[k];
            nc  = st_c[k];
            rc  = 1'b0;
            pb  = 1'b0;
            bp  = 1'b0;
            idx = 0;
            for (int j = LO; j < HI; j++) begin
                rc = nc;
                bp = 1'b1;
                for (int t = 0; t < BLK; t++) begin
                    idx     = j * BLK + t;
                    pb      = st_a[k][idx] ^ st_b[k][idx];
                    ns[idx] = pb ^ rc;
                    rc      = (st_a[k][idx] & st_b[k][idx]) | (pb & rc);
                    bp      = bp & pb;
                end
                // A fully propagating block forwards its carry-in without waiting on the ripple.
                nc = bp ? nc : rc;
            end
        end

        // Stage k may load when every stage from k to the output is either empty or draining.
        assign en[k] = out_ready || !(&v_q[L-1:k]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (en[k]) begin
                v_r <= st_v[k];
                if (st_v[k]) begin
                    s_r <= ns;
                    c_r <= nc;
                end
            end
        end

        assign v_q[k]   = v_r;
        assign c_q[k]   = c_r;
        assign sum_q[k] = s_r;

        if (k < L - 1) begin : g_ops
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (en[k] && st_v[k]) begin
                    a_r <= st_a[k];
                    b_r <= st_b[k];
                end
            end

            assign opa_q[k] = a_r;
            assign opb_q[k] = b_r;
        end else begin : g_tail
            logic o_r;

            // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_r <= 1'b0;
                end else if (en[k] && st_v[k]) begin
                    o_r <= nc ^ (ns[WIDTH-1] ^ st_a[k][WIDTH-1] ^ st_b[k][WIDTH-1]);
                end
            end

            assign ovf_q = o_r;
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[L-1];
    assign sum       = sum_q[L-1];
    assign cout      = c_q[L-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cska_pipe.sv
// Bench for cska_pipe: three configurations (32/4/2, 16/4/1, 64/8/3) against an arithmetic model.
module tb_cska_pipe;
    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        iv   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic        ci   [3];
    logic        si   [3];
    logic        co   [3];
    logic        vf   [3];
    logic [63:0] ai   [3];
    logic [63:0] bi   [3];
    logic [31:0] s0;
    logic [15:0] s1;
    logic [63:0] s2;
    int          wd   [3] = '{32, 16, 64};

    int          total = 0;
    int          bad   = 0;
    exp_t        q    [3][$];
    logic        held [3];
    logic [63:0] hs   [3];
    logic        hc   [3];
    logic        ho   [3];
    logic [63:0] cur_s;
    exp_t        e_c;

    cska_pipe #(.WIDTH(32), .BLK(4), .BPS(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(ai[0][31:0]), .b(bi[0][31:0]), .cin(ci[0]), .sub(si[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .ovf(vf[0])
    );
    cska_pipe #(.WIDTH(16), .BLK(4), .BPS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(ai[1][15:0]), .b(bi[1][15:0]), .cin(ci[1]), .sub(si[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .ovf(vf[1])
    );
    cska_pipe #(.WIDTH(64), .BLK(8), .BPS(3)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(ai[2]), .b(bi[2]), .cin(ci[2]), .sub(si[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .ovf(vf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] getsum(input int i);
        case (i)
            0:       getsum = {32'd0, s0};
            1:       getsum = {48'd0, s1};
            default: getsum = s2;
        endcase
    endfunction

    // Reference: plain integer add of a, b-or-~b and carry, truncated to w bits.
    function automatic exp_t ref_calc(input logic [63:0] x, input logic [63:0] y,
                                      input logic c, input logic s, input int w);
        exp_t        r;
        logic [64:0] m;
        logic [64:0] t;
        logic [63:0] ye;
        m     = (65'd1 << w) - 65'd1;
        ye    = s ? ~y : y;
        t     = {1'b0, x & m[63:0]} + {1'b0, ye & m[63:0]} + (s ? 65'd1 : {64'd0, c});
        r.s   = t[63:0] & m[63:0];
        r.c   = t[w];
        r.o   = (x[w-1] == ye[w-1]) && (r.s[w-1] != x[w-1]);
        return r;
    endfunction

    function automatic logic [63:0] pick(input int w);
        case ($urandom_range(5))
            0:       pick = '0;
            1:       pick = '1;
            2:       pick = (64'd1 << (w - 1)) - 64'd1;
            3:       pick = 64'd1 << (w - 1);
            4:       pick = {$urandom, $urandom} >> $urandom_range(63);
            default: pick = {$urandom, $urandom};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                q[i].delete();
                held[i] = 1'b0;
                chk($sformatf("u%0d_reset_out_valid", i), ov[i], 0);
            end else begin
                cur_s = getsum(i);
                if (held[i]) begin
                    chk($sformatf("u%0d_hold_valid", i), ov[i], 1);
                    chk($sformatf("u%0d_hold_sum", i), cur_s, hs[i]);
                    chk($sformatf("u%0d_hold_cout", i), co[i], hc[i]);
                    chk($sformatf("u%0d_hold_ovf", i), vf[i], ho[i]);
                end
                if (ov[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("u%0d_spurious_out", i), ov[i], 0);
                    end else begin
                        e_c = q[i][0];
                        chk($sformatf("u%0d_sum", i), cur_s, e_c.s);
                        chk($sformatf("u%0d_cout", i), co[i], e_c.c);
                        chk($sformatf("u%0d_ovf", i), vf[i], e_c.o);
                        if (ordy[i]) void'(q[i].pop_front());
                    end
                end
                held[i] = ov[i] && !ordy[i];
                hs[i]   = cur_s;
                hc[i]   = co[i];
                ho[i]   = vf[i];
                if (iv[i] && ir[i]) q[i].push_back(ref_calc(ai[i], bi[i], ci[i], si[i], wd[i]));
            end
        end
    end

    // One beat on u0 with literal expectations and a 4-cycle latency check.
    task automatic send1(input string nm, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic s,
                         input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        iv[0]   = 1'b1;
        ai[0]   = {32'd0, x};
        bi[0]   = {32'd0, y};
        ci[0]   = c;
        si[0]   = s;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, ir[0], 1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov[0] && lat < 20);
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_sum"}, s0, es);
        chk({nm, "_cout"}, co[0], ec);
        chk({nm, "_ovf"}, vf[0], eo);
        @(posedge clk); #1;
    endtask

    task automatic rand_run(input int i, input int n);
        int acc = 0;
        int del = 0;
        int cyc = 0;
        while ((acc < n || del < acc) && cyc < n * 4) begin
            iv[i]   = (acc < n) && ($urandom_range(3) != 0);
            ai[i]   = pick(wd[i]);
            bi[i]   = pick(wd[i]);
            ci[i]   = 1'($urandom);
            si[i]   = 1'($urandom);
            ordy[i] = $urandom_range(9) > 2;
            @(negedge clk);
            if (iv[i] && ir[i]) acc++;
            if (ov[i] && ordy[i]) del++;
            @(posedge clk); #1;
            cyc++;
        end
        iv[i] = 1'b0;
        chk($sformatf("u%0d_rand_drained", i), del, n);
    endtask

    initial begin
        int acc;
        int del;
        int n;
        logic seen;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; ai[i] = '0; bi[i] = '0; ci[i] = 1'b0; si[i] = 1'b0;
            held[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("init_out_valid", ov[0], 0);
        chk("init_sum", s0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_in_ready", ir[0], 1);
        @(posedge clk); #1;

        send1("skip_chain", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send1("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send1("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send1("sub_pos", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        send1("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Idle reset with a non-zero result sitting in the output register.
        rst_n = 1'b0;
        #1;
        chk("idle_rst_valid", ov[0], 0);
        chk("idle_rst_sum", s0, 0);
        chk("idle_rst_cout", co[0], 0);
        chk("idle_rst_ovf", vf[0], 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rst_in_ready", ir[0], 1);
        @(posedge clk); #1;

        acc = 0; del = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 40 && del < 8; cyc++) begin
            iv[0]   = acc < 8;
            ai[0]   = 64'(acc);
            bi[0]   = 64'(acc) << 4;
            ci[0]   = 1'b0;
            si[0]   = 1'b0;
            ordy[0] = !(cyc >= 3 && cyc <= 8);
            @(negedge clk);
            if (!ir[0]) begin
                seen = 1'b1;
                chk("bp_occupancy", acc - del, 4);
            end
            if (iv[0] && ir[0]) acc++;
            if (ov[0] && ordy[0]) del++;
            @(posedge clk); #1;
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        chk("bp_in_ready_fell", seen, 1);
        chk("bp_all_delivered", del, 8);

        ordy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[0] = 1'b1;
            ai[0] = 64'(100 + k);
            bi[0] = 64'(k);
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_flight_valid", ov[0], 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_flight_drop", ov[0], 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ordy[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_no_stale", ov[0], 0);
        end
        @(posedge clk); #1;
        send1("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            fork
                automatic int ii = i;
                rand_run(ii, 10000);
            join_none
        end
        wait fork;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
